// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Latency: none (declarations only).
// Backpressure: none.
// Contents: the sequencer state enum and the saturation value of the
// lock-loss event counter.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    HOLD,
    RELEASE,
    RUN
  } reset_seq_state_t;

  // Lock-loss counter stops here instead of wrapping back to zero.
  localparam logic [7:0] LOST_SAT = 8'd255;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit, with synchronous clear.
// Latency: d_i sampled at edge n appears on q_o after edge n+DEPTH-1.
// Backpressure: none; a level shorter than one clock may be lost.
// Ports: clk_i destination clock, clr_i synchronous clear of every flop,
//        d_i asynchronous input, q_o synchronised output (last flop).
module sync_bit #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  // Flops are kept together and marked for metastability-aware placement.
  (* ASYNC_REG = "TRUE" *) (* keep = "true" *)
  logic [DEPTH-1:0] sync_q = '0;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-up / lock-loss reset sequencer: waits for stable PLL lock, then
// releases STAGES active-high resets in order, bit 0 first.
// Latency: rst_out[k] falls SYNC_DEPTH+HOLD_CYCLES+k*STAGE_GAP edges after the
// edge that first samples locked=1. Backpressure: none; all outputs registered.
// Ports: clk_pix clock, rst_pix sync active-high reset, locked async PLL lock,
//        rst_out per-stage reset, ready all stages released,
//        lock_lost_count saturating count of lock losses after release.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int SYNC_DEPTH  = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int STAGE_GAP   = 16
) (
  input  logic              clk_pix,
  input  logic              rst_pix,
  input  logic              locked,
  output logic [STAGES-1:0] rst_out,
  output logic              ready,
  output logic [7:0]        lock_lost_count
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int IW = $clog2(STAGES + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(STAGES - 1);

  logic locked_s;

  sync_bit #(
    .DEPTH(SYNC_DEPTH)
  ) u_lock_sync (
    .clk_i(clk_pix),
    .clr_i(rst_pix),
    .d_i  (locked),
    .q_o  (locked_s)
  );

  // Power-on values match the reset values: rst_pix may be tied low.
  reset_seq_state_t  state_q     = ASSERT;
  logic [HW-1:0]     hold_cnt_q  = '0;
  logic [GW-1:0]     gap_cnt_q   = '0;
  logic [IW-1:0]     stage_idx_q = '0;
  logic [STAGES-1:0] rst_out_q   = '1;
  logic              ready_q     = 1'b0;
  logic [7:0]        lost_cnt_q  = '0;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      // Wins over a simultaneous lock loss, which is therefore not counted.
      state_q     <= ASSERT;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      stage_idx_q <= '0;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
      lost_cnt_q  <= '0;
    end else begin
      case (state_q)
        ASSERT: begin
          rst_out_q   <= '1;
          ready_q     <= 1'b0;
          hold_cnt_q  <= '0;
          gap_cnt_q   <= '0;
          stage_idx_q <= '0;
          if (locked_s) begin
            state_q <= HOLD;
          end
        end

        HOLD: begin
          if (!locked_s) begin
            // Lock never released anything yet: not a counted loss.
            state_q    <= ASSERT;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            rst_out_q[0] <= 1'b0;
            hold_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            stage_idx_q  <= IW'(1);
            if (STAGES == 1) begin
              ready_q <= 1'b1;
              state_q <= RUN;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end

        RELEASE: begin
          if (!locked_s) begin
            state_q     <= ASSERT;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            gap_cnt_q   <= '0;
            stage_idx_q <= '0;
            if (lost_cnt_q != LOST_SAT) begin
              lost_cnt_q <= lost_cnt_q + 8'd1;
            end
          end else if (gap_cnt_q == GAP_LAST) begin
            // Decoded clear keeps the index select within rst_out's range.
            for (int k = 0; k < STAGES; k++) begin
              if (stage_idx_q == IW'(k)) begin
                rst_out_q[k] <= 1'b0;
              end
            end
            gap_cnt_q   <= '0;
            stage_idx_q <= stage_idx_q + IW'(1);
            if (stage_idx_q == IDX_LAST) begin
              ready_q <= 1'b1;
              state_q <= RUN;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end

        RUN: begin
          if (!locked_s) begin
            state_q     <= ASSERT;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            gap_cnt_q   <= '0;
            stage_idx_q <= '0;
            if (lost_cnt_q != LOST_SAT) begin
              lost_cnt_q <= lost_cnt_q + 8'd1;
            end
          end
        end

        default: begin
          state_q   <= ASSERT;
          rst_out_q <= '1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rst_out         = rst_out_q;
  assign ready           = ready_q;
  assign lock_lost_count = lost_cnt_q;

endmodule
